// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
// Optional divide-by-zero fast path: DIV_ZERO_FAST_EN.
module restoring_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state;
    logic [DIVISOR_W-1:0]    r;
    logic [DIVIDEND_W-1:0]   q;
    logic [DIVISOR_W-1:0]    d;
    logic [CNT_W-1:0]        cnt;

    logic [DIVISOR_W:0]      r_shift;
    logic                    fit;
    logic [DIVISOR_W-1:0]    r_next;
    logic [DIVIDEND_W-1:0]   q_next;

    // Stored remainder drops the top bit: after a restore it is below the
    // divisor, and with a zero divisor the top bit is shifted out next cycle.
    always_comb begin
        r_shift = {r, q[DIVIDEND_W-1]};
        fit     = (r_shift >= {1'b0, d});
        r_next  = fit ? (r_shift[DIVISOR_W-1:0] - d) : r_shift[DIVISOR_W-1:0];
        q_next  = {q[DIVIDEND_W-2:0], fit};
    end

`ifdef DIV_ZERO_FAST_EN
    logic dbz_q;
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            r         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_FAST_EN
            dbz_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        r     <= '0;
                        q     <= dividend;
                        d     <= divisor;
                        cnt   <= '0;
                    end
                end
                RUN: begin
`ifdef DIV_ZERO_FAST_EN
                    if (d == '0) begin
                        // q still holds the untouched dividend on the first RUN cycle
                        state     <= DONE;
                        done      <= 1'b1;
                        quotient  <= '1;
                        remainder <= q[DIVISOR_W-1:0];
                        dbz_q     <= 1'b1;
                    end else
`endif
                    begin
                        r <= r_next;
                        q <= q_next;
                        if (cnt == LAST_ITER) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= q_next;
                            remainder <= r_next;
`ifdef DIV_ZERO_FAST_EN
                            dbz_q     <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - scoreboard bench for restoring_divider
module tb_restoring_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        int q;
        int r;
        int dbz;
        int lat;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_pushed = 0;
    int   cyc      = 0;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 1;
    localparam int ZERO_DBZ = 1;
`else
    localparam int ZERO_LAT = 8;
    localparam int ZERO_DBZ = 0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", int'(quotient), e.q);
                check("remainder", int'(remainder), e.r);
                check("div_by_zero", int'(div_by_zero), e.dbz);
                check("latency", cyc - e.acc, e.lat);
            end
        end
    end

    task automatic do_div(input int a, input int b, input int eq, input int er,
                          input int edz, input int lat, input bit push);
        int t;
        exp_t e;
        t = 0;
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("wait_idle_timeout", 1, 0);
        start    = 1'b1;
        dividend = 8'(a);
        divisor  = 4'(b);
        if (push) begin
            e.q = eq; e.r = er; e.dbz = edz; e.lat = lat; e.acc = cyc + 1;
            sb.push_back(e);
            n_pushed++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        rst = 1'b0;
        @(negedge clk);

        do_div(200, 7, 28, 4, 0, 8, 1'b1);
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, 9);

        do_div(255, 1, 255, 0, 0, 8, 1'b1);
        do_div(13, 15, 0, 13, 0, 8, 1'b1);
        do_div(0, 5, 0, 0, 0, 8, 1'b1);

        do_div(8'hA5, 0, 8'hFF, 5, ZERO_DBZ, ZERO_LAT, 1'b1);
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("zero_busy_cycles", n, ZERO_LAT + 1);

        // Starts during RUN cycle 3, RUN cycle 8 and DONE are all dropped.
        do_div(77, 6, 12, 5, 0, 8, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1; dividend = 8'd9; divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        check("done_at_k8", int'(done), 1);
        start = 1'b1; dividend = 8'd99; divisor = 4'd9;
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        check("ignored_start_idle", int'(busy), 0);

        // Reset at RUN cycle 4 discards the in-flight division.
        do_div(100, 3, 0, 0, 0, 8, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_quotient", int'(quotient), 0);
        check("midrst_remainder", int'(remainder), 0);
        check("midrst_dbz", int'(div_by_zero), 0);
        repeat (10) @(negedge clk);
        do_div(100, 3, 33, 1, 0, 8, 1'b1);

        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_div(a, b, a / b, a % b, 0, 8, 1'b1);
            end
        end

        n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        check("done_count", n_done, n_pushed);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
